// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: blank pattern and active-low hex glyph table.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] HEX_GLYPHS [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
        return HEX_GLYPHS[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low seven-segment glyph.
// Kept as its own block so other display drivers can reuse it.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg7(i_nibble);

endmodule

// File: rtl/seg7_sum_scanner.sv
// Captures input0+input1 on in_valid and shows the sum in hex on DIGITS
// time-multiplexed common-anode digits, with optional leading-zero blanking.
module seg7_sum_scanner
    import seg7_pkg::*;
#(
    parameter int IN_W     = 3,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   input0,
    input  logic [IN_W-1:0]   input1,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an,
    output logic [IN_W:0]     sum_q
);

    localparam int SUM_W = IN_W + 1;
    localparam int PAD_W = 4 * DIGITS;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (PAD_W < SUM_W) begin : g_chk_digits
        $fatal(1, "seg7_sum_scanner: 4*DIGITS must cover IN_W+1 sum bits");
    end
    if (SCAN_DIV < 2) begin : g_chk_div
        $fatal(1, "seg7_sum_scanner: SCAN_DIV must be at least 2");
    end

    logic [SUM_W-1:0]  r_sum;
    logic [DIV_W-1:0]  r_div;
    logic [IDX_W-1:0]  r_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic              w_tick;
    logic [IDX_W-1:0]  w_next_idx;
    logic [PAD_W-1:0]  w_padded;
    logic [PAD_W-1:0]  w_upper;
    logic [3:0]        w_nibble;
    logic              w_blank;
    logic [6:0]        w_dec_seg;

    // Everything below is computed for the digit the coming tick will select,
    // so the output registers load glyph and enable for the same digit together.
    always_comb begin
        w_tick     = (r_div == DIV_W'(SCAN_DIV - 1));
        w_next_idx = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
        w_padded   = PAD_W'(r_sum);
        w_upper    = w_padded >> {w_next_idx, 2'b00};
        w_nibble   = w_upper[3:0];
        w_blank    = blank_lz && (w_next_idx != '0) && (w_upper == '0);
    end

    seg7_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    // NOTE: state registers use non-blocking assignments so every block reads
    // pre-edge values; a tick coinciding with in_valid thus decodes the old sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (in_valid) begin
            r_sum <= {1'b0, input0} + {1'b0, input1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= '0;
            r_seg <= SEG_OFF;
            r_an  <= '1;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_idx <= w_next_idx;
                r_an  <= ~(DIGITS'(1) << w_next_idx);
                r_seg <= w_blank ? SEG_OFF : w_dec_seg;
            end
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign sum_q = r_sum;

endmodule

// File: tb/tb_seg7_sum_scanner.sv
// Directed self-checking bench: reset, capture, scanning, blanking, tick-edge
// capture, a wide-operand instance and a full glyph sweep.
module tb_seg7_sum_scanner;

    localparam logic [6:0] G_OFF = 7'b1111111;
    localparam logic [6:0] G_0   = 7'b1000000;
    localparam logic [6:0] G_3   = 7'b0110000;
    localparam logic [6:0] G_7   = 7'b1111000;
    localparam logic [6:0] G_B   = 7'b0000011;
    localparam logic [6:0] G_E   = 7'b0000110;

    logic [6:0] exp_glyph [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // main instance: IN_W=3, DIGITS=2, SCAN_DIV=4
    logic       in_valid, blank_lz;
    logic [2:0] input0, input1;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] sum_q;

    // wide instance: IN_W=5
    logic       in_valid5, blank_lz5;
    logic [4:0] input0_5, input1_5;
    logic [6:0] seg5;
    logic [1:0] an5;
    logic [5:0] sum_q5;

    // sweep instance: IN_W=4
    logic       in_valid4, blank_lz4;
    logic [3:0] input0_4, input1_4;
    logic [6:0] seg4;
    logic [1:0] an4;
    logic [4:0] sum_q4;

    seg7_sum_scanner #(.IN_W(3), .DIGITS(2), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .input0(input0), .input1(input1),
        .blank_lz(blank_lz), .seg(seg), .an(an), .sum_q(sum_q)
    );

    seg7_sum_scanner #(.IN_W(5), .DIGITS(2), .SCAN_DIV(4)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid5), .input0(input0_5), .input1(input1_5),
        .blank_lz(blank_lz5), .seg(seg5), .an(an5), .sum_q(sum_q5)
    );

    seg7_sum_scanner #(.IN_W(4), .DIGITS(2), .SCAN_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .input0(input0_4), .input1(input1_4),
        .blank_lz(blank_lz4), .seg(seg4), .an(an4), .sum_q(sum_q4)
    );

    function automatic logic [1:0] get_an(input int which);
        case (which)
            0:       return an;
            1:       return an5;
            default: return an4;
        endcase
    endfunction

    function automatic logic [6:0] get_seg(input int which);
        case (which)
            0:       return seg;
            1:       return seg5;
            default: return seg4;
        endcase
    endfunction

    // Wait for the next tick that switches the given instance to exp_an.
    task automatic wait_sel(input int which, input logic [1:0] exp_an, input int budget,
                            output bit ok, output int cycles);
        logic [1:0] prev;
        prev   = get_an(which);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (get_an(which) !== prev && get_an(which) === exp_an) ok = 1'b1;
            prev = get_an(which);
        end
    endtask

    task automatic expect_sel(input string name, input int which, input logic [1:0] exp_an,
                              input logic [6:0] exp_seg);
        bit ok;
        int cyc;
        wait_sel(which, exp_an, 20, ok, cyc);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: an never became %b (now %b)", name, exp_an, get_an(which));
        end else if (get_seg(which) !== exp_seg) begin
            failures++;
            $display("FAIL %s: seg=%b expected %b", name, get_seg(which), exp_seg);
        end
    endtask

    task automatic load_main(input logic [2:0] a, input logic [2:0] b);
        input0   = a;
        input1   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        int first;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (seg !== G_OFF || an !== 2'b11 || sum_q !== 4'd0 || an5 !== 2'b11) begin
            failures++;
            $display("FAIL reset_hold: seg=%b an=%b sum=%0d an5=%b expected 1111111/11/0/11",
                     seg, an, sum_q, an5);
        end
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            @(posedge clk);
            #1;
            if (an !== 2'b11) first = i;
        end
        checks++;
        if (first != 4 || an !== 2'b01) begin
            failures++;
            $display("FAIL reset_first_tick: change after %0d cycles to an=%b expected 4 / 01", first, an);
        end
        load_main(3'd2, 3'd3);
        checks++;
        if (sum_q !== 4'd5) begin
            failures++;
            $display("FAIL capture_2p3: sum=%0d expected 5", sum_q);
        end
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (seg !== G_OFF || an !== 2'b11 || sum_q !== 4'd0) begin
            failures++;
            $display("FAIL reset_midscan: seg=%b an=%b sum=%0d expected 1111111/11/0", seg, an, sum_q);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        first = 0;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            @(posedge clk);
            #1;
            if (an !== 2'b11) first = i;
        end
        checks++;
        if (first != 4 || an !== 2'b01) begin
            failures++;
            $display("FAIL restart_first_tick: change after %0d cycles to an=%b expected 4 / 01", first, an);
        end
    endtask

    task automatic test_sum_no_blank;
        bit ok;
        int cyc;
        blank_lz = 1'b0;
        load_main(3'd7, 3'd7);
        checks++;
        if (sum_q !== 4'd14) begin
            failures++;
            $display("FAIL capture_7p7: sum=%0d expected 14", sum_q);
        end
        expect_sel("sum14_digit0", 0, 2'b10, G_E);
        wait_sel(0, 2'b01, 20, ok, cyc);
        checks++;
        if (!ok || cyc != 4 || seg !== G_0) begin
            failures++;
            $display("FAIL sum14_digit1: ok=%0d cycles=%0d seg=%b expected 1/4/%b", ok, cyc, seg, G_0);
        end
        wait_sel(0, 2'b10, 20, ok, cyc);
        checks++;
        if (!ok || cyc != 4) begin
            failures++;
            $display("FAIL scan_period: ok=%0d cycles=%0d expected 1/4", ok, cyc);
        end
    endtask

    task automatic test_blank;
        blank_lz = 1'b1;
        expect_sel("blank14_digit1", 0, 2'b01, G_OFF);
        expect_sel("blank14_digit0", 0, 2'b10, G_E);
        load_main(3'd0, 3'd0);
        checks++;
        if (sum_q !== 4'd0) begin
            failures++;
            $display("FAIL capture_0p0: sum=%0d expected 0", sum_q);
        end
        expect_sel("blank0_digit0", 0, 2'b10, G_0);
        expect_sel("blank0_digit1", 0, 2'b01, G_OFF);
        blank_lz = 1'b0;
        expect_sel("noblank0_digit1", 0, 2'b01, G_0);
    endtask

    task automatic test_hold;
        logic [6:0] want;
        load_main(3'd5, 3'd6);
        expect_sel("sum11_digit0", 0, 2'b10, G_B);
        expect_sel("sum11_digit1", 0, 2'b01, G_0);
        for (int i = 0; i < 32; i++) begin
            input0 = 3'(i);
            input1 = 3'(7 - (i % 8));
            @(posedge clk);
            #1;
            want = (an === 2'b10) ? G_B : G_0;
            checks++;
            if (sum_q !== 4'd11 || seg !== want) begin
                failures++;
                $display("FAIL hold_cycle%0d: sum=%0d seg=%b expected 11/%b", i, sum_q, seg, want);
            end
        end
    endtask

    task automatic test_tick_edge;
        bit ok;
        int cyc;
        expect_sel("pre_tick_digit1", 0, 2'b01, G_0);
        repeat (3) @(posedge clk);
        #1;
        input0   = 3'd3;
        input1   = 3'd4;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (an !== 2'b10 || seg !== G_B || sum_q !== 4'd7) begin
            failures++;
            $display("FAIL tick_edge_old: an=%b seg=%b sum=%0d expected 10/%b/7", an, seg, sum_q, G_B);
        end
        wait_sel(0, 2'b10, 20, ok, cyc);
        checks++;
        if (!ok || cyc != 8 || seg !== G_7) begin
            failures++;
            $display("FAIL tick_edge_new: ok=%0d cycles=%0d seg=%b expected 1/8/%b", ok, cyc, seg, G_7);
        end
    endtask

    task automatic test_wide;
        input0_5  = 5'd31;
        input1_5  = 5'd31;
        in_valid5 = 1'b1;
        @(posedge clk);
        #1;
        in_valid5 = 1'b0;
        checks++;
        if (sum_q5 !== 6'd62) begin
            failures++;
            $display("FAIL wide_sum: sum=%0d expected 62", sum_q5);
        end
        expect_sel("wide_digit1", 1, 2'b01, G_3);
        expect_sel("wide_digit0", 1, 2'b10, G_E);
    endtask

    task automatic test_sweep;
        for (int n = 0; n < 16; n++) begin
            input0_4  = 4'(n / 2);
            input1_4  = 4'(n - n / 2);
            in_valid4 = 1'b1;
            @(posedge clk);
            #1;
            in_valid4 = 1'b0;
            checks++;
            if (sum_q4 !== 5'(n)) begin
                failures++;
                $display("FAIL sweep_sum%0d: sum=%0d expected %0d", n, sum_q4, n);
            end
            expect_sel($sformatf("sweep_glyph%0d", n), 2, 2'b10, exp_glyph[n]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0; blank_lz  = 1'b0; input0   = '0; input1   = '0;
        in_valid5 = 1'b0; blank_lz5 = 1'b0; input0_5 = '0; input1_5 = '0;
        in_valid4 = 1'b0; blank_lz4 = 1'b0; input0_4 = '0; input1_4 = '0;
        test_reset;
        test_sum_no_blank;
        test_blank;
        test_hold;
        test_tick_edge;
        test_wide;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_sum_scanner.md
Name: seg7_sum_scanner

Overview:
- Parametrised successor to the single-digit sum-to-seven-segment decoder.
- Registers the sum of two IN_W-bit operands on a valid strobe and shows it as hex on DIGITS time-multiplexed common-anode 7-segment digits.
- Supports optional leading-zero blanking.
- Sits between the board switches/operand logic and the display pins.

Parameters:
- IN_W, 3: operand width in bits; sum width is IN_W+1.
- DIGITS, 2: number of multiplexed digits; must satisfy 4*DIGITS >= IN_W+1 (elaboration-time check; fatal if violated).
- SCAN_DIV, 50000: clock cycles each digit stays selected; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  capture strobe for input0/input1.
- input0  in  IN_W  operand A, unsigned.
- input1  in  IN_W  operand B, unsigned.
- blank_lz  in  1  1 = blank leading zero digits.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  out  DIGITS  digit enables, active-low one-hot, registered.
- sum_q  out  IN_W+1  registered sum.

Behaviour:
- Reset (async assert, sync release):
  - sum_q=0, seg=7'b1111111, an=all ones.
  - Divider count=0, digit index=0.
- Capture:
  - in_valid=1 at edge N loads sum_q=input0+input1, zero-extended to IN_W+1 bits, with no truncation; sum_q is visible after edge N.
  - in_valid=0 holds sum_q.
- Scan divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On each wrap (tick), the digit index advances idx -> idx+1; DIGITS-1 wraps to 0.
- Display registers: on each tick edge, with k the new index:
  - an <= all ones except bit k = 0.
  - seg <= decode(nibble k of sum_q, zero-padded to 4*DIGITS bits).
  - The first tick after reset selects digit 1 (index advances from 0). If DIGITS=1, every tick reselects digit 0.
  - Between ticks, seg and an are stable.
  - A new sum_q reaches digit k on the next tick that selects k. Worst-case display latency is DIGITS*SCAN_DIV+1 cycles.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking:
  - With blank_lz=1, digit k>0 outputs 1111111 when it and all higher nibbles are 0.
  - Digit 0 is never blanked, so sum 0 shows "0".
  - an is still driven normally for blanked digits.
  - blank_lz is sampled at the tick edge.
- Simultaneous events:
  - in_valid on a tick edge: the tick decodes the old sum_q, and the new value appears from the next selection onward.
  - rst overrides everything.
  - Reset mid-scan blanks the display immediately and restarts the scan from index 0.

Decomposition:
- Package seg7_pkg:
  - SEG_OFF constant (7'b1111111).
  - 16-entry hex glyph table.
  - Function hex_to_seg7(nibble).
- Sub-module seg7_decode (combinational nibble -> seg, wraps hex_to_seg7). Used by the top and reusable by other display blocks.
- Top holds the capture register, divider, index counter, blanking logic and output registers.

Test Plan (IN_W=3, DIGITS=2, SCAN_DIV=4 unless stated):
- Reset: hold rst, pulse mid-scan -> seg=1111111, an=11, sum_q=0 immediately; after release the first an change is exactly 4 cycles later, to an=01.
- Sum 7+7, blank_lz=0 -> sum_q=14 one edge after in_valid. Digit0 (an=10) seg=0000110 ("E"); digit1 (an=01) seg=1000000 ("0"). an rotates every 4 cycles.
- Same sum, blank_lz=1 -> digit1 seg=1111111 while an=01. Then 0+0 -> digit0 seg=1000000 and digit1 blank.
- in_valid=0 with changing inputs -> sum_q and seg pattern unchanged over 32 cycles. in_valid asserted on a tick edge -> that tick shows the old digit, and the next selection of that digit shows the new one.
- IN_W=5, DIGITS=2: 31+31 -> sum_q=62 (0x3E), digit1 seg=0110000 ("3"), digit0 seg=0000110 ("E").
- Sweep all 16 nibbles via IN_W=4 operand pairs -> seg matches the decode table exactly, including F=0001110.
